// File: rtl/dm_sba_responder_pkg.sv
// Shared types and counter widths for the SBA-side responder.
package dm_sba_responder_pkg;

  typedef enum logic [1:0] {
    RspIdle,
    RspWait,
    RspBusy
  } rsp_state_e;

  localparam int unsigned WaitCntW = 4;
  localparam int unsigned LatCntW  = 2;

endpackage

// File: rtl/dm_sba_responder_mem.sv
// Depth x BusWidth RAM, per-byte write enable, registered read on one shared port.
module dm_sba_responder_mem #(
  parameter int unsigned BusWidth = 32,
  parameter int unsigned Depth    = 256,
  parameter int unsigned IdxW     = $clog2(Depth)
) (
  input  logic                  clk_i,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [IdxW-1:0]       i_addr,
  input  logic [BusWidth-1:0]   i_wdata,
  input  logic [BusWidth/8-1:0] i_be,
  output logic [BusWidth-1:0]   o_rdata
);

  logic [BusWidth-1:0] r_mem [Depth];
  logic [BusWidth-1:0] r_rdata;

  // Contents are deliberately not reset; the read register only moves on reads.
  always_ff @(posedge clk_i) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < BusWidth / 8; i++) begin
          if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_sba_responder.sv
// System-bus target for the debug module: req/gnt command side, one-cycle r_valid
// response, with programmable grant wait-states and response latency.
module dm_sba_responder
  import dm_sba_responder_pkg::*;
#(
  parameter int unsigned          BusWidth    = 32,
  parameter int unsigned          Depth       = 256,
  parameter logic [BusWidth-1:0]  BaseAddr    = '0,
  parameter int unsigned          WaitCycles  = 0,
  parameter int unsigned          RespLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slave_req_i,
  input  logic [BusWidth-1:0]   slave_add_i,
  input  logic                  slave_we_i,
  input  logic [BusWidth-1:0]   slave_wdata_i,
  input  logic [BusWidth/8-1:0] slave_be_i,
  output logic                  slave_gnt_o,
  output logic                  slave_r_valid_o,
  output logic [BusWidth-1:0]   slave_r_rdata_o,
  output logic                  slave_r_err_o
);

  localparam int unsigned AddrLsb = $clog2(BusWidth / 8);
  localparam int unsigned IdxW    = $clog2(Depth);

  rsp_state_e          r_state;
  logic [WaitCntW-1:0] r_wait_cnt;
  logic [LatCntW-1:0]  r_lat_cnt;
  logic                r_valid;
  logic                r_err;
  logic                r_rd_ok;
  logic [BusWidth-1:0] w_off;
  logic [BusWidth-1:0] w_mem_rdata;
  logic                w_in_range;
  logic                w_gnt;
  logic                w_unused;

  assign w_off      = slave_add_i - BaseAddr;
  assign w_in_range = (slave_add_i >= BaseAddr) &&
                      ((w_off >> (AddrLsb + IdxW)) == {BusWidth{1'b0}});
  // Sub-word address bits carry no meaning; lanes come from the byte enables.
  assign w_unused   = ^w_off[AddrLsb-1:0];

  always_comb begin
    w_gnt = 1'b0;
    case (r_state)
      RspIdle: w_gnt = slave_req_i && (WaitCycles == 0);
      RspWait: w_gnt = slave_req_i && (r_wait_cnt == '0);
      default: w_gnt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= RspIdle;
      r_wait_cnt <= '0;
      r_lat_cnt  <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else if (w_gnt) begin
      r_state   <= RspBusy;
      r_lat_cnt <= LatCntW'(RespLatency - 1);
      r_valid   <= (RespLatency == 1);
      r_err     <= !w_in_range;
      r_rd_ok   <= w_in_range && !slave_we_i;
    end else begin
      case (r_state)
        RspIdle: begin
          if (slave_req_i) begin
            r_wait_cnt <= WaitCntW'(WaitCycles - 1);
            r_state    <= RspWait;
          end
        end
        RspWait: begin
          if (!slave_req_i) r_state <= RspIdle;
          else              r_wait_cnt <= r_wait_cnt - 1'b1;
        end
        RspBusy: begin
          // r_valid is raised one edge early so it is a clean registered pulse.
          if (r_lat_cnt == '0) begin
            r_state <= RspIdle;
            r_valid <= 1'b0;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
            r_valid   <= (r_lat_cnt == LatCntW'(1));
          end
        end
        default: r_state <= RspIdle;
      endcase
    end
  end

  dm_sba_responder_mem #(
    .BusWidth (BusWidth),
    .Depth    (Depth),
    .IdxW     (IdxW)
  ) u_mem (
    .clk_i   (clk_i),
    .i_en    (w_gnt && w_in_range),
    .i_we    (slave_we_i),
    .i_addr  (w_off[AddrLsb +: IdxW]),
    .i_wdata (slave_wdata_i),
    .i_be    (slave_be_i),
    .o_rdata (w_mem_rdata)
  );

  assign slave_gnt_o     = w_gnt;
  assign slave_r_valid_o = r_valid;
  assign slave_r_err_o   = r_err;
  assign slave_r_rdata_o = r_rd_ok ? w_mem_rdata : '0;

endmodule

// File: tb/tb_dm_sba_responder.sv
// Directed bench: three responder configurations sharing clock, reset and command bus.
module tb_dm_sba_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] add, wdata;
  logic        we;
  logic [3:0]  be;
  logic        req_a, req_b, req_c;
  logic        gnt_a, gnt_b, gnt_c;
  logic        rv_a, rv_b, rv_c;
  logic        err_a, err_b, err_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic [31:0] rd;
  logic        err;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  dm_sba_responder #(.BusWidth(32), .Depth(256), .BaseAddr(32'h1000),
                     .WaitCycles(0), .RespLatency(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_a), .slave_add_i(add),
    .slave_we_i(we), .slave_wdata_i(wdata), .slave_be_i(be),
    .slave_gnt_o(gnt_a), .slave_r_valid_o(rv_a), .slave_r_rdata_o(rd_a),
    .slave_r_err_o(err_a));

  dm_sba_responder #(.BusWidth(32), .Depth(256), .BaseAddr(32'h0),
                     .WaitCycles(3), .RespLatency(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_b), .slave_add_i(add),
    .slave_we_i(we), .slave_wdata_i(wdata), .slave_be_i(be),
    .slave_gnt_o(gnt_b), .slave_r_valid_o(rv_b), .slave_r_rdata_o(rd_b),
    .slave_r_err_o(err_b));

  dm_sba_responder #(.BusWidth(32), .Depth(256), .BaseAddr(32'h0),
                     .WaitCycles(0), .RespLatency(3)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_c), .slave_add_i(add),
    .slave_we_i(we), .slave_wdata_i(wdata), .slave_be_i(be),
    .slave_gnt_o(gnt_c), .slave_r_valid_o(rv_c), .slave_r_rdata_o(rd_c),
    .slave_r_err_o(err_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on instance A: grant in the request cycle, r_valid the next.
  task automatic tx_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] o_rd, output logic o_err);
    @(negedge clk);
    req_a = 1'b1; we = w; add = a; wdata = d; be = b;
    #1 chk("a_gnt", gnt_a, 1);
    @(negedge clk);
    req_a = 1'b0;
    #1 chk("a_rvalid", rv_a, 1);
    o_rd  = rd_a;
    o_err = err_a;
  endtask

  // Instance B: req from cycle 0 to 3, grant at 3, r_valid at 7.
  task automatic b_run(input logic w, input logic [31:0] d, input logic [31:0] exp_rd);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_b = (c <= 3); we = w; add = 32'h40; wdata = d; be = 4'hF;
      #1;
      chk("b_gnt", gnt_b, (c == 3));
      chk("b_rvalid", rv_b, (c == 7));
      if (c == 7) begin
        chk("b_rdata", rd_b, exp_rd);
        chk("b_err", err_b, 0);
      end
    end
  endtask

  // Instance C: single-cycle req, grant at 0, r_valid at 3.
  task automatic c_run(input logic w, input logic [31:0] d, input logic [31:0] exp_rd);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_c = (c == 0); we = w; add = 32'h8; wdata = d; be = 4'hF;
      #1;
      chk("c_gnt", gnt_c, (c == 0));
      chk("c_rvalid", rv_c, (c == 3));
      if (c == 3) chk("c_rdata", rd_c, exp_rd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    we = 1'b0; add = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", gnt_a, 0);
    chk("rst_rvalid", rv_a, 0);
    chk("rst_rdata", rd_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read
    tx_a(1'b1, 32'h1010, 32'hDEADBEEF, 4'hF, rd, err);
    chk("wr_rdata_zero", rd, 0);
    chk("wr_err", err, 0);
    tx_a(1'b0, 32'h1010, 32'h0, 4'hF, rd, err);
    chk("rd_basic", rd, 32'hDEADBEEF);
    chk("rd_basic_err", err, 0);
    @(negedge clk);
    #1 chk("rdata_hold", rd_a, 32'hDEADBEEF);
    chk("rvalid_pulse", rv_a, 0);

    // Byte enables, be=0 write, ignored low address bits, read not masked by be
    tx_a(1'b1, 32'h1020, 32'h11223344, 4'hF, rd, err);
    tx_a(1'b1, 32'h1020, 32'hAABBCCDD, 4'b0101, rd, err);
    tx_a(1'b0, 32'h1020, 32'h0, 4'hF, rd, err);
    chk("be_merge", rd, 32'h11BB33DD);
    tx_a(1'b1, 32'h1020, 32'hFFFFFFFF, 4'b0000, rd, err);
    tx_a(1'b0, 32'h1023, 32'h0, 4'b0001, rd, err);
    chk("be_zero_unchanged", rd, 32'h11BB33DD);

    // Range edges and out-of-range accesses
    tx_a(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, rd, err);
    tx_a(1'b1, 32'h13FC, 32'h0BADC0DE, 4'hF, rd, err);
    tx_a(1'b0, 32'h13FC, 32'h0, 4'hF, rd, err);
    chk("top_word", rd, 32'h0BADC0DE);
    chk("top_word_err", err, 0);
    tx_a(1'b0, 32'h0FFC, 32'h0, 4'hF, rd, err);
    chk("below_rdata", rd, 0);
    chk("below_err", err, 1);
    tx_a(1'b0, 32'h1400, 32'h0, 4'hF, rd, err);
    chk("above_rdata", rd, 0);
    chk("above_err", err, 1);
    tx_a(1'b1, 32'h1400, 32'h12345678, 4'hF, rd, err);
    chk("oor_wr_err", err, 1);
    tx_a(1'b0, 32'h1000, 32'h0, 4'hF, rd, err);
    chk("oor_wr_discarded", rd, 32'hCAFEF00D);
    chk("after_oor_err", err, 0);

    // Busy ignore with req held continuously
    @(negedge clk);
    req_a = 1'b1; we = 1'b0; add = 32'h1010; be = 4'hF;
    #1 chk("bb_gnt0", gnt_a, 1);
    @(negedge clk);
    #1 chk("bb_busy_gnt", gnt_a, 0);
    chk("bb_rvalid0", rv_a, 1);
    chk("bb_rdata0", rd_a, 32'hDEADBEEF);
    @(negedge clk);
    #1 chk("bb_gnt1", gnt_a, 1);
    chk("bb_rvalid_gap", rv_a, 0);
    @(negedge clk);
    req_a = 1'b0;
    #1 chk("bb_rvalid1", rv_a, 1);

    // Wait states and latency on B
    b_run(1'b1, 32'h00C0FFEE, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_b = (c < 2);
      #1;
      chk("drop_gnt", gnt_b, 0);
      chk("drop_rvalid", rv_b, 0);
    end
    b_run(1'b0, 32'h0, 32'h00C0FFEE);

    // Reset one cycle after a read grant on C
    c_run(1'b1, 32'h000055AA, 32'h0);
    @(negedge clk);
    req_c = 1'b1; we = 1'b0; add = 32'h8;
    #1 chk("c_rd_gnt", gnt_c, 1);
    @(negedge clk);
    req_c = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt_c, 0);
    chk("mid_rst_rvalid", rv_c, 0);
    chk("mid_rst_rdata", rd_c, 0);
    chk("mid_rst_err", err_c, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 chk("post_rst_no_rvalid", rv_c, 0);
    end
    c_run(1'b0, 32'h0, 32'h000055AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
